seg_display_scheduler: RTL
==========================

SEG_DISPLAY_SCHEDULER -- requirements
Module: seg_display_scheduler

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000, meaning clock cycles per sub-tick (1 kHz at 50 MHz).
REQ-002 SHALL have port clock  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port dataA  input  16  display source 0, four hex nibbles, [15:12] leftmost.
REQ-005 SHALL have port dataB  input  16  display source 1, same layout.
REQ-006 SHALL have port selToggle  input  1  single-cycle pulse that flips the selected source.
REQ-007 SHALL have port brightness  input  4  per-slot duty, 0 = dark, 15 = 15/16 on.
REQ-008 SHALL have port blankLeadingZeros  input  1  enables leading-zero suppression.
REQ-009 SHALL have port segment  output  8  active-high {dp,g,f,e,d,c,b,a}.
REQ-010 SHALL have port digit  output  4  one-hot active-high enable; digit[i] drives position i, position 0 leftmost.
REQ-011 SHALL have port sourceSel  output  1  currently selected source (0 = dataA).
REQ-012 SHALL have port frameStart  output  1  one-cycle pulse when a new frame is latched.

Function
REQ-013 SHALL count clock cycles 0..TICK_DIV-1, asserting an internal tick on count TICK_DIV-1, then wrapping to 0.
REQ-014 SHALL advance a 4-bit subCount on each tick; when it wraps 15->0, the digit index SHALL advance 0->1->2->3->0.
REQ-015 Slot = 16 ticks; frame = 4 slots = 64*TICK_DIV cycles.
REQ-016 On the tick that wraps index 3->0, SHALL latch the selected source into a 16-bit frame buffer and pulse frameStart for exactly one cycle.
REQ-017 Frame latch SHALL use sourceSel as held before that edge; a simultaneous selToggle applies from the following frame.
REQ-018 selToggle SHALL flip sourceSel on the next edge; displayed data SHALL change only at the next frame latch (no tearing).
REQ-019 SHALL latch brightness only at slot start (tick where subCount wraps to 0); mid-slot changes take effect next slot.
REQ-020 Within a slot, digit SHALL be one-hot at the current index while subCount < latched brightness, else 4'b0000.
REQ-021 SHALL decode the current nibble with standard hex patterns (0=0x3F,1=0x06,2=0x5B,5=0x6D,E=0x79,F=0x71); dp always 0.
REQ-022 With blankLeadingZeros=1, position i<3 SHALL be blanked when nibbles 0..i are all zero; position 3 SHALL never be blanked.
REQ-023 A blanked or dark position SHALL drive segment=0 and digit=0.
REQ-024 segment and digit SHALL be registered, reflecting the state updated on the previous edge (one-cycle latency).
REQ-025 blankLeadingZeros SHALL be evaluated combinationally against the frame buffer each cycle.

Reset
REQ-026 While reset is high at an edge: all counters, index, frame buffer, latched brightness SHALL become 0; segment=0, digit=0, sourceSel=0, frameStart=0.
REQ-027 Reset mid-frame SHALL abort the frame; scanning restarts at position 0, subCount 0, with a dark display until the first frame latch.
REQ-028 selToggle coincident with reset SHALL be ignored.

Structure
REQ-029 Package seg_display_pkg SHALL hold NUM_DIGITS=4, SLOT_TICKS=16, and the 16-entry hex segment pattern constant.
REQ-030 SHALL instantiate one combinational sub-module hex7seg_decoder (4-bit nibble in, 8-bit segment out).
REQ-031 Prescaler, scan counters, source select and output registers SHALL reside in seg_display_scheduler.

Verification (TICK_DIV=2, frame = 128 cycles)
REQ-032 Reset held 3 cycles -> segment=0, digit=0, sourceSel=0, frameStart=0; first frameStart 128 cycles after release.
REQ-033 dataA=16'h12EF, brightness=15, blanking off -> frame shows 0x06/0x5B/0x79/0x71 on digit 0001/0010/0100/1000, each on 15 of 16 ticks.
REQ-034 dataA=16'h0050, blanking on -> positions 0,1 dark, position 2 0x6D, position 3 0x3F; dataA=0 -> only position 3 lit with 0x3F.
REQ-035 dataB=16'hBEEF, selToggle pulse during position 1 -> sourceSel=1 next cycle; display stays dataA until next frameStart, then shows BEEF.
REQ-036 brightness=0 -> digit=0000 for a full frame; brightness 0->8 mid-slot -> current slot dark, next slot lit 8 of 16 ticks.
REQ-037 Reset asserted during position 2 -> all outputs 0 next cycle; scan resumes at position 0, frameStart after 128 cycles.

Source files
------------

// File: rtl/seg_display_pkg.sv
// Shared constants for the multiplexed 4-digit seven-segment scheduler.
// HEX_SEG is indexed by nibble value; bit order {dp,g,f,e,d,c,b,a}, active-high.
package seg_display_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int SLOT_TICKS = 16;

  localparam logic [15:0][7:0] HEX_SEG = {
    8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
    8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

endpackage

// File: rtl/hex7seg_decoder.sv
// Combinational hex nibble to seven-segment decoder; decimal point is never lit.
module hex7seg_decoder
  import seg_display_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [7:0] o_seg
);

  assign o_seg = {1'b0, HEX_SEG[i_nibble][6:0]};

endmodule

// File: rtl/seg_display_scheduler.sv
// Time-multiplexed 4-digit display scanner: prescaled sub-ticks give per-slot PWM
// brightness, and a frame buffer refreshed only at frame boundaries prevents tearing.
module seg_display_scheduler
  import seg_display_pkg::*;
#(
  parameter int TICK_DIV = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] dataA,
  input  logic [15:0] dataB,
  input  logic        selToggle,
  input  logic [3:0]  brightness,
  input  logic        blankLeadingZeros,
  output logic [7:0]  segment,
  output logic [3:0]  digit,
  output logic        sourceSel,
  output logic        frameStart
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [DIV_W-1:0] r_div;
  logic [3:0]       r_sub;
  logic [1:0]       r_idx;
  logic [3:0]       r_bright;
  logic [15:0]      r_fb;
  logic             r_fvld;
  logic             r_sel;
  logic             r_fs;
  logic [7:0]       r_seg;
  logic [3:0]       r_dig;

  logic       w_tick;
  logic       w_slot_wrap;
  logic       w_frame_wrap;
  logic [3:0] w_nib;
  logic       w_blank;
  logic       w_lit;
  logic [7:0] w_seg;

  assign w_tick       = (r_div == DIV_W'(TICK_DIV - 1));
  assign w_slot_wrap  = w_tick && (r_sub == 4'(SLOT_TICKS - 1));
  assign w_frame_wrap = w_slot_wrap && (r_idx == 2'(NUM_DIGITS - 1));

  // Position 0 is the leftmost digit, i.e. the most significant nibble.
  always_comb begin
    w_nib   = 4'h0;
    w_blank = 1'b0;
    case (r_idx)
      2'd0: begin
        w_nib   = r_fb[15:12];
        w_blank = (r_fb[15:12] == 4'h0);
      end
      2'd1: begin
        w_nib   = r_fb[11:8];
        w_blank = (r_fb[15:8] == 8'h00);
      end
      2'd2: begin
        w_nib   = r_fb[7:4];
        w_blank = (r_fb[15:4] == 12'h000);
      end
      default: begin
        w_nib   = r_fb[3:0];
        w_blank = 1'b0;
      end
    endcase
  end

  assign w_lit = r_fvld && (r_sub < r_bright) && !(blankLeadingZeros && w_blank);

  hex7seg_decoder u_dec (
    .i_nibble (w_nib),
    .o_seg    (w_seg)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_div    <= '0;
      r_sub    <= '0;
      r_idx    <= '0;
      r_bright <= '0;
      r_fb     <= '0;
      r_fvld   <= 1'b0;
      r_sel    <= 1'b0;
      r_fs     <= 1'b0;
      r_seg    <= '0;
      r_dig    <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick) begin
        r_sub <= r_sub + 1'b1;
      end
      if (w_slot_wrap) begin
        r_idx    <= r_idx + 1'b1;
        r_bright <= brightness;
      end
      // Frame latch sees the source select as it was before this edge.
      if (w_frame_wrap) begin
        r_fb   <= r_sel ? dataB : dataA;
        r_fvld <= 1'b1;
      end
      r_fs  <= w_frame_wrap;
      r_sel <= r_sel ^ selToggle;
      r_seg <= w_lit ? w_seg : 8'h00;
      r_dig <= w_lit ? (4'b0001 << r_idx) : 4'b0000;
    end
  end

  assign segment    = r_seg;
  assign digit      = r_dig;
  assign sourceSel  = r_sel;
  assign frameStart = r_fs;

endmodule
